elevator_control: RTL and testbench



---
 rtl/elevator_control.sv | 201 ++++++++++++++++++++
 tb/tb_elevator_control.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_control.sv
// elevator_control: SCAN-style control FSM for the elevator car.
// Consumes the datapath's request flags and one-hot floor vector and
// issues one-cycle open/up/down strobes; travel and door dwell are timed
// with an internal down-counter.
// Optional feature: define ELEVATOR_HOME_EN to return an idle car to the
// bottom floor after HOME_CYCLES quiet cycles.
module elevator_control #(
    parameter int N             = 5,
    parameter int TRAVEL_CYCLES = 3,
    parameter int DOOR_CYCLES   = 4,
    parameter int HOME_CYCLES   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         request_i,
    input  logic         request_j_gt_i,
    input  logic         request_j_lt_i,
    input  logic [N-1:0] i,
    output logic         open,
    output logic         up,
    output logic         down,
    output logic         door_open,
    output logic         moving,
    output logic         dir_up
);

    localparam int MAX_TD  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int MAX_CYC = (MAX_TD > HOME_CYCLES) ? MAX_TD : HOME_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DOOR,
        S_TRAVEL,
        S_STEP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          go_up_q, go_up_d;     // direction of the move in progress
    logic          dir_up_q, dir_up_d;   // remembered SCAN preference
    logic          open_q, open_d;
    logic          up_q, up_d;
    logic          down_q, down_d;
    logic          door_open_q, door_open_d;
    logic          moving_q, moving_d;

    logic          floor_valid;
    logic          can_up;
    logic          can_dn;

`ifdef ELEVATOR_HOME_EN
    localparam logic [CW-1:0] HOME_LOAD = CW'(HOME_CYCLES - 1);

    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          homing_q, homing_d;   // keep stepping down once homing has begun
    logic          any_req;
    logic          home_go;
`endif

    // A floor vector with no bit set is treated as "position unknown": the
    // car is not moved until the datapath reports a real floor again.
    assign floor_valid = |i;
    assign can_up      = request_j_gt_i && floor_valid && !i[N-1];
    assign can_dn      = request_j_lt_i && floor_valid && !i[0];

`ifdef ELEVATOR_HOME_EN
    assign any_req = request_i || request_j_gt_i || request_j_lt_i;
    assign home_go = !any_req && floor_valid && !i[0] &&
                     (homing_q || (idle_cnt_q == HOME_LOAD));
`endif

    // Next-state, counter and strobe computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        go_up_d  = go_up_q;
        dir_up_d = dir_up_q;
        open_d   = 1'b0;
        up_d     = 1'b0;
        down_d   = 1'b0;
`ifdef ELEVATOR_HOME_EN
        idle_cnt_d = '0;
        homing_d   = homing_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (request_i) begin
                    state_d = S_DOOR;
                    cnt_d   = DOOR_LOAD;
                    open_d  = 1'b1;
                end else if (dir_up_q ? can_up : (can_up && !can_dn)) begin
                    state_d  = S_TRAVEL;
                    cnt_d    = TRAVEL_LOAD;
                    go_up_d  = 1'b1;
                    dir_up_d = 1'b1;
                end else if (can_dn) begin
                    state_d  = S_TRAVEL;
                    cnt_d    = TRAVEL_LOAD;
                    go_up_d  = 1'b0;
                    dir_up_d = 1'b0;
`ifdef ELEVATOR_HOME_EN
                end else if (home_go) begin
                    state_d  = S_TRAVEL;
                    cnt_d    = TRAVEL_LOAD;
                    go_up_d  = 1'b0;
                    dir_up_d = 1'b0;
`endif
                end
`ifdef ELEVATOR_HOME_EN
                if (any_req || !floor_valid || i[0]) begin
                    homing_d = 1'b0;
                end else if (home_go) begin
                    homing_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + CW'(1);
                end
`endif
            end

            S_DOOR: begin
                // The open cycle is when the datapath clears this floor's
                // request, so request_i seen then is not a fresh press.
                if (request_i && !open_q) begin
                    cnt_d  = DOOR_LOAD;
                    open_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_TRAVEL: begin
                if (cnt_q == '0) begin
                    state_d = S_STEP;
                    up_d    = go_up_q && !i[N-1];
                    down_d  = !go_up_q && !i[0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_STEP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        door_open_d = (state_d == S_DOOR);
        moving_d    = (state_d == S_TRAVEL) || (state_d == S_STEP);
    end

    // State, counters and registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            go_up_q     <= 1'b1;
            dir_up_q    <= 1'b1;
            open_q      <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            door_open_q <= 1'b0;
            moving_q    <= 1'b0;
`ifdef ELEVATOR_HOME_EN
            idle_cnt_q  <= '0;
            homing_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            go_up_q     <= go_up_d;
            dir_up_q    <= dir_up_d;
            open_q      <= open_d;
            up_q        <= up_d;
            down_q      <= down_d;
            door_open_q <= door_open_d;
            moving_q    <= moving_d;
`ifdef ELEVATOR_HOME_EN
            idle_cnt_q  <= idle_cnt_d;
            homing_q    <= homing_d;
`endif
        end
    end

    assign open      = open_q;
    assign up        = up_q;
    assign down      = down_q;
    assign door_open = door_open_q;
    assign moving    = moving_q;
    assign dir_up    = dir_up_q;

endmodule

// File: tb/tb_elevator_control.sv
// Bench for elevator_control: a table of one-shot decisions from IDLE,
// hand-written multi-cycle sequences (latency, door dwell and re-open,
// direction preference, top-floor guard, reset mid-travel) and a random
// run against a datapath stand-in plus a behavioural car model.
module tb_elevator_control;

    localparam int N  = 5;
    localparam int TC = 3;
    localparam int DC = 4;
    localparam int HC = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         request_i = 1'b0;
    logic         request_j_gt_i = 1'b0;
    logic         request_j_lt_i = 1'b0;
    logic [N-1:0] i_vec = 5'b00001;
    logic         open, up, down, door_open, moving, dir_up;
    logic [5:0]   dut_outs;

    int total = 0;
    int bad   = 0;

    elevator_control #(
        .N(N), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC), .HOME_CYCLES(HC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .request_i(request_i), .request_j_gt_i(request_j_gt_i),
        .request_j_lt_i(request_j_lt_i), .i(i_vec),
        .open(open), .up(up), .down(down),
        .door_open(door_open), .moving(moving), .dir_up(dir_up)
    );

    always #5 clk = ~clk;

    // Output word order: {open, up, down, door_open, moving, dir_up}
    assign dut_outs = {open, up, down, door_open, moving, dir_up};

    task automatic chk(input string name, input logic [5:0] want);
        total++;
        if (dut_outs !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b (open,up,down,door_open,moving,dir_up) t=%0t",
                     name, dut_outs, want, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        request_i      = 1'b0;
        request_j_gt_i = 1'b0;
        request_j_lt_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_flags();
        i_vec = 5'b00001;
        tick();
        chk("reset_state", 6'b000001);
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural car model ----------------
    // The car is either idle, dwelling with the door open for a number of
    // remaining cycles, or moving for TC+1 cycles with the strobe on the last.
    localparam int M_IDLE = 0;
    localparam int M_DOOR = 1;
    localparam int M_MOVE = 2;

    int   m_mode;
    int   m_rem;
    logic m_first;
    logic m_mv_up;
    logic m_dir_up;
    int   m_idle;
    logic m_homing;

    task automatic model_reset();
        m_mode = M_IDLE; m_rem = 0; m_first = 1'b0;
        m_mv_up = 1'b1; m_dir_up = 1'b1; m_idle = 0; m_homing = 1'b0;
    endtask

    function automatic logic [5:0] model_out();
        logic strobe;
        strobe = (m_mode == M_MOVE) && (m_rem == 1);
        return {(m_mode == M_DOOR) && m_first, strobe && m_mv_up, strobe && !m_mv_up,
                m_mode == M_DOOR, m_mode == M_MOVE, m_dir_up};
    endfunction

    task automatic start_move(input logic go_up);
        m_mode = M_MOVE; m_rem = TC + 1; m_mv_up = go_up; m_dir_up = go_up;
    endtask

    task automatic model_step(input logic ri, input logic gt, input logic lt, input logic [N-1:0] iv);
        logic up_ok, dn_ok;
        up_ok = gt && !iv[N-1];
        dn_ok = lt && !iv[0];
        if (m_mode == M_IDLE) begin
            if (ri) begin
                m_mode = M_DOOR; m_rem = DC; m_first = 1'b1;
            end else if (m_dir_up && up_ok) start_move(1'b1);
            else if (m_dir_up && dn_ok)     start_move(1'b0);
            else if (!m_dir_up && dn_ok)    start_move(1'b0);
            else if (!m_dir_up && up_ok)    start_move(1'b1);
`ifdef ELEVATOR_HOME_EN
            if (ri || gt || lt || iv[0]) begin
                m_idle = 0; m_homing = 1'b0;
            end else if (m_homing || m_idle == HC - 1) begin
                start_move(1'b0); m_homing = 1'b1; m_idle = 0;
            end else begin
                m_idle++;
            end
`endif
        end else if (m_mode == M_DOOR) begin
            m_idle = 0;
            if (ri && !m_first) begin
                m_rem = DC; m_first = 1'b1;
            end else begin
                m_first = 1'b0;
                if (m_rem == 1) m_mode = M_IDLE;
                else m_rem--;
            end
        end else begin
            m_idle = 0;
            if (m_rem == 1) m_mode = M_IDLE;
            else m_rem--;
        end
    endtask

    // ---------------- decision table ----------------
    typedef struct {
        logic         ri, gt, lt;
        logic [N-1:0] iv;
        logic [5:0]   exp1;   // one cycle after the decision
        logic [5:0]   exp4;   // TC+1 cycles after the decision
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [N-1:0] one;
        logic [5:0]   prev;
        int           f;
        logic [N-1:0] req;
        int           downs, others;

        one = 1;
        vecs[0] = '{1'b1, 1'b1, 1'b1, 5'b00100, 6'b100101, 6'b000101};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 5'b00100, 6'b000011, 6'b010011};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 5'b00100, 6'b000010, 6'b001010};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 5'b10000, 6'b000001, 6'b000001};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 5'b10000, 6'b000010, 6'b001010};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 5'b00001, 6'b000001, 6'b000001};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 5'b00100, 6'b000001, 6'b000001};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 5'b10000, 6'b100101, 6'b000101};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 5'b00001, 6'b000011, 6'b010011};

        for (int v = 0; v < 9; v++) begin
            do_reset();
            request_i = vecs[v].ri; request_j_gt_i = vecs[v].gt;
            request_j_lt_i = vecs[v].lt; i_vec = vecs[v].iv;
            tick();
            clear_flags();
            chk($sformatf("vec%0d_decide", v), vecs[v].exp1);
            repeat (TC) tick();
            chk($sformatf("vec%0d_strobe", v), vecs[v].exp4);
            $display("vector %0d applied: ri=%b gt=%b lt=%b i=%b", v,
                     vecs[v].ri, vecs[v].gt, vecs[v].lt, vecs[v].iv);
        end

        // Latency from floor 0: moving t+1..t+4, up only at t+4, idle at t+5.
        do_reset();
        request_j_gt_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("lat_travel_t%0d", k), 6'b000011);
        end
        tick();
        chk("lat_up_t4", 6'b010011);
        i_vec = 5'b00010; request_j_gt_i = 1'b0;
        tick();
        chk("lat_idle_t5", 6'b000001);
        $display("sequence latency done");

        // Door dwell: open at t+1 only, door_open t+1..t+4, idle t+5.
        do_reset();
        request_i = 1'b1;
        tick();
        chk("door_open_t1", 6'b100101);
        for (int k = 2; k <= 4; k++) begin
            tick();
            request_i = 1'b0;
            chk($sformatf("door_dwell_t%0d", k), 6'b000101);
        end
        tick();
        chk("door_close_t5", 6'b000001);
        $display("sequence door dwell done");

        // Re-press at the 3rd door cycle: open again at t+4, close at t+8.
        do_reset();
        request_i = 1'b1;
        tick();
        chk("reopen_t1", 6'b100101);
        tick();
        request_i = 1'b0;
        chk("reopen_t2", 6'b000101);
        tick();
        request_i = 1'b1;
        chk("reopen_t3", 6'b000101);
        tick();
        chk("reopen_pulse_t4", 6'b100101);
        for (int k = 5; k <= 7; k++) begin
            tick();
            request_i = 1'b0;
            chk($sformatf("reopen_dwell_t%0d", k), 6'b000101);
        end
        tick();
        chk("reopen_close_t8", 6'b000001);
        $display("sequence door re-open done");

        // Direction preference: up wins while dir_up=1, then down alone flips it.
        do_reset();
        i_vec = 5'b00100; request_j_gt_i = 1'b1; request_j_lt_i = 1'b1;
        tick();
        clear_flags();
        chk("dir_both_up", 6'b000011);
        repeat (TC) tick();
        chk("dir_up_strobe", 6'b010011);
        i_vec = 5'b01000; request_j_lt_i = 1'b1;
        tick();
        chk("dir_idle", 6'b000001);
        tick();
        clear_flags();
        chk("dir_down_flip", 6'b000010);
        repeat (TC) tick();
        chk("dir_down_strobe", 6'b001010);
        $display("sequence direction done");

        // Top floor with a request pointing past the end: never moves.
        do_reset();
        i_vec = 5'b10000; request_j_gt_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("top_guard_c%0d", k), 6'b000001);
        end
        clear_flags();
        $display("sequence top-floor guard done");

        // Reset mid-travel aborts with no strobe, then idles.
        do_reset();
        i_vec = 5'b00100; request_j_lt_i = 1'b1;
        tick();
        clear_flags();
        chk("rst_pre_travel", 6'b000010);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_async", 6'b000001);
        tick();
        tick();
        chk("rst_held", 6'b000001);
        rst_n = 1'b1;
        tick();
        chk("rst_after_release", 6'b000001);
        tick();
        chk("rst_idle_stays", 6'b000001);
        $display("sequence reset mid-travel done");

`ifdef ELEVATOR_HOME_EN
        // Homing from floor 2 with no requests: two down steps, nothing else.
        do_reset();
        i_vec = 5'b00100; f = 2; downs = 0; others = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (down) begin
                downs++;
                if (f > 0) f--;
                i_vec = one << f;
            end
            if (up || open) others++;
        end
        chk_int("home_downs", downs, 2);
        chk_int("home_other_strobes", others, 0);
        chk_int("home_floor", f, 0);
        $display("sequence homing done");
`endif

        // Random run: bench acts as the datapath, model predicts outputs.
        do_reset();
        model_reset();
        f = 0; req = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) req[$urandom_range(0, N - 1)] = 1'b1;
            i_vec = one << f;
            request_i = req[f];
            request_j_gt_i = 1'b0;
            request_j_lt_i = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (req[k] && k > f) request_j_gt_i = 1'b1;
                if (req[k] && k < f) request_j_lt_i = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) begin
                if (f == N - 1) request_j_gt_i = 1'b1;
                if (f == 0)     request_j_lt_i = 1'b1;
            end
            tick();
            prev = model_out();
            model_step(request_i, request_j_gt_i, request_j_lt_i, i_vec);
            if (prev[5]) req[f] = 1'b0;
            if (prev[4] && f < N - 1) f++;
            if (prev[3] && f > 0) f--;
            chk($sformatf("random_c%0d", c), model_out());
        end
        $display("random run done: floor=%0d pending=%b", f, req);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
